// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes the payload of a SYNC/LEN/DATA frame into program memory.
// Define PROG_LOADER_CKSUM_EN to require and verify a trailing modulo-256 checksum byte.
module prog_loader #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1000000,
  parameter int         TW      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] wAddr,
  output logic [7:0] din,
  output logic       write_en,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
`ifdef PROG_LOADER_CKSUM_EN
  localparam logic [2:0] ST_CKSUM = 3'd3;
`endif
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          hold_q, hold_d;
  logic          we_q, we_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    waddr_q, waddr_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic accept;
  logic inFrame;

  assign in_ready = (state_q != ST_DONE);
  assign accept   = in_valid && in_ready;
`ifdef PROG_LOADER_CKSUM_EN
  assign inFrame  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CKSUM);
`else
  assign inFrame  = (state_q == ST_LEN) || (state_q == ST_DATA);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    din_d   = din_q;
    waddr_d = waddr_q;
`ifdef PROG_LOADER_CKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept && (in_data == SYNC)) begin
          state_d = ST_LEN;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          addr_d  = 8'd0;
          tmo_d   = '0;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      ST_LEN: begin
        if (accept) begin
          cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          din_d   = in_data;
          waddr_d = addr_q;
          addr_d  = addr_q + 8'd1;
          cnt_d   = cnt_q - 9'd1;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d   = sum_q + in_data;
          if (cnt_q == 9'd1) state_d = ST_CKSUM;
`else
          if (cnt_q == 9'd1) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
          end
`endif
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (accept) begin
          busy_d = 1'b0;
          if (in_data == sum_q) begin
            state_d = ST_DONE;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The idle counter only matters mid-frame; reaching TIMEOUT abandons the frame but keeps the CPU held.
    if (inFrame) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        tmo_d   = '0;
        state_d = ST_IDLE;
        err_d   = 1'b1;
        busy_d  = 1'b0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 9'd0;
      addr_q  <= 8'd0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      we_q    <= 1'b0;
      din_q   <= 8'd0;
      waddr_q <= 8'd0;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      din_q   <= din_d;
      waddr_q <= waddr_d;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign wAddr    = waddr_q;
  assign din      = din_q;
  assign write_en = we_q;
  assign cpu_hold = hold_q;
  assign busy     = busy_q;
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;

endmodule
